// File: rtl/shift_counter.sv
// WIDTH-bit shift counter running as a ring (one-hot) or Johnson (twisted-ring) counter,
// with parallel load, self-correction of illegal states, wrap/illegal pulses and a phase index.
module shift_counter #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             wrap,
   output logic             illegal,
   output logic [PW-1:0]    phase
);

   typedef enum logic {
      RING    = 1'b0,
      JOHNSON = 1'b1
   } mode_e;

   localparam logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_e            cur_mode;
   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] step_val;
   logic [PW:0]      ones;
   logic [PW:0]      trans;
   logic             legal;
   logic [PW-1:0]    ring_idx;

   assign cur_mode = mode_e'(mode);
   assign seed     = (cur_mode == JOHNSON) ? '0 : RING_SEED;

   // Legality and phase are derived from the set-bit count and the number of adjacent-bit edges.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      ones     = '0;
      trans    = '0;
      ring_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + {{PW{1'b0}}, q_q[i]};
         if (q_q[i]) ring_idx = PW'(i);
      end
      for (int i = 0; i < WIDTH-1; i++) begin
         trans = trans + {{PW{1'b0}}, q_q[i] ^ q_q[i+1]};
      end

      if (cur_mode == RING) legal = (ones == (PW+1)'(1));
      else                  legal = (trans <= (PW+1)'(1));

      if (!legal) begin
         phase = '0;
      end else if (cur_mode == RING) begin
         phase = ring_idx;
      end else if (q_q[0] || (q_q == '0)) begin
         phase = ones[PW-1:0];
      end else begin
         phase = PW'(2*WIDTH) - ones[PW-1:0];
      end
   end

   always_comb begin
      unique case ({cur_mode, dir})
         {RING,    1'b0}: step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         {RING,    1'b1}: step_val = {q_q[0], q_q[WIDTH-1:1]};
         {JOHNSON, 1'b0}: step_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
         default:         step_val = {~q_q[0], q_q[WIDTH-1:1]};
      endcase
   end

   // Priority: load, then enabled step (or correction), then hold.
   always_comb begin
      q_d       = q_q;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         if (!legal) begin
            q_d       = seed;
            illegal_d = 1'b1;
         end else begin
            q_d    = step_val;
            wrap_d = (step_val == seed);
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (clr) begin
         q_q       <= RING_SEED;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign Q       = q_q;
   assign wrap    = wrap_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_counter.sv
// Self-checking bench for shift_counter: a sequence-table model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_shift_counter;

   localparam int W  = 4;
   localparam int PW = $clog2(2*W);

   logic          clk = 1'b0;
   logic          clr;
   logic          en, mode, dir, load;
   logic [W-1:0]  load_val;
   logic [W-1:0]  Q;
   logic          wrap, illegal;
   logic [PW-1:0] phase;

   int errors = 0;
   int checks = 0;

   shift_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .Q        (Q),
      .wrap     (wrap),
      .illegal  (illegal),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic         wrap;
      logic         ill;
   } mstate_t;

   mstate_t m;

   // k-th pattern of the left-shift sequence; k=0 is the seed.
   function automatic logic [W-1:0] seq_val(bit md, int k);
      logic [W-1:0] one  = 1;
      logic [W-1:0] mask = '1;
      if (!md)    return one << k;
      if (k <= W) return (one << k) - 1;
      return mask ^ ((one << (k - W)) - 1);
   endfunction

   function automatic int idx_of(bit md, logic [W-1:0] v);
      int p = md ? 2*W : W;
      for (int k = 0; k < p; k++)
         if (seq_val(md, k) === v) return k;
      return -1;
   endfunction

   function automatic logic [PW-1:0] exp_phase(bit md, logic [W-1:0] v);
      int i = idx_of(md, v);
      return (i < 0) ? '0 : PW'(i);
   endfunction

   function automatic mstate_t model_next(mstate_t s, bit ld, logic [W-1:0] lv,
                                          bit e, bit md, bit d);
      mstate_t n;
      int p = md ? 2*W : W;
      int i = idx_of(md, s.q);
      int ni;
      n.q = s.q; n.wrap = 1'b0; n.ill = 1'b0;
      if (ld) begin
         n.q = lv;
      end else if (e) begin
         if (i < 0) begin
            n.q   = seq_val(md, 0);
            n.ill = 1'b1;
         end else begin
            ni     = d ? (i - 1 + p) % p : (i + 1) % p;
            n.q    = seq_val(md, ni);
            n.wrap = (ni == 0);
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge clr) begin
      if (clr) m <= '{q: W'(1), wrap: 1'b0, ill: 1'b0};
      else     m <= model_next(m, load, load_val, en, mode, dir);
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cyc_q",       32'(Q),       32'(m.q));
      check("cyc_wrap",    32'(wrap),    32'(m.wrap));
      check("cyc_illegal", 32'(illegal), 32'(m.ill));
      check("cyc_phase",   32'(phase),   32'(exp_phase(mode, m.q)));
   end

   task automatic drive(bit ld, logic [W-1:0] lv, bit e, bit md, bit d);
      load = ld; load_val = lv; en = e; mode = md; dir = d;
      @(posedge clk);
      #2;
   endtask

   task automatic run(string nm, bit ld, logic [W-1:0] lv, bit e, bit md, bit d,
                      logic [W-1:0] eq, bit ew, bit ei);
      drive(ld, lv, e, md, d);
      check({nm, "_q"},       32'(Q),       32'(eq));
      check({nm, "_wrap"},    32'(wrap),    32'(ew));
      check({nm, "_illegal"}, 32'(illegal), 32'(ei));
   endtask

   logic [W-1:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [W-1:0] john_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
   logic [W-1:0] john_r [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [W-1:0] ring_r [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
   logic [PW-1:0] john_ph [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

   initial begin
      clr = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
      #23 clr = 1'b0;
      check("rst_q", 32'(Q), 32'h1);
      check("rst_phase", 32'(phase), 32'h0);

      for (int k = 0; k < 4; k++) begin
         run("ring_left", 0, '0, 1, 0, 0, ring_l[k], k == 3, 0);
         check("ring_left_phase", 32'(phase), 32'((k + 1) % 4));
      end

      run("load_zero", 1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0);
      for (int k = 0; k < 8; k++) begin
         run("john_left", 0, '0, 1, 1, 0, john_l[k], k == 7, 0);
         check("john_left_phase", 32'(phase), 32'(john_ph[k]));
      end
      for (int k = 0; k < 8; k++)
         run("john_right", 0, '0, 1, 1, 1, john_r[k], k == 7, 0);

      run("load_seed", 1, 4'b0001, 0, 0, 1, 4'b0001, 0, 0);
      for (int k = 0; k < 4; k++)
         run("ring_right", 0, '0, 1, 0, 1, ring_r[k], k == 3, 0);
      for (int k = 0; k < 3; k++)
         run("hold", 0, 4'b1111, 0, 0, 1, 4'b0001, 0, 0);

      run("load_0110", 1, 4'b0110, 0, 0, 0, 4'b0110, 0, 0);
      run("fix_ring",  0, '0, 1, 0, 0, 4'b0001, 0, 1);
      run("load_0101", 1, 4'b0101, 0, 1, 0, 4'b0101, 0, 0);
      run("fix_john",  0, '0, 1, 1, 0, 4'b0000, 0, 1);
      run("after_fix", 0, '0, 1, 1, 0, 4'b0001, 0, 0);

      run("load_prio",  1, 4'b0100, 1, 0, 0, 4'b0100, 0, 0);
      run("mode_swap",  0, '0, 1, 1, 0, 4'b0000, 0, 1);

      for (int k = 0; k < 3; k++)
         run("pre_clr", 0, '0, 1, 1, 0, john_l[k], 0, 0);
      #1 clr = 1'b1;
      #1;
      check("clr_q",       32'(Q),       32'h1);
      check("clr_wrap",    32'(wrap),    32'h0);
      check("clr_illegal", 32'(illegal), 32'h0);
      check("clr_phase",   32'(phase),   32'h1);
      #1 clr = 1'b0;
      run("post_clr", 0, '0, 1, 1, 0, 4'b0011, 0, 0);

      for (int n = 0; n < 600; n++) begin
         logic md;
         md = mode;
         if ($urandom_range(7) == 0) md = ~md;
         if ($urandom_range(63) == 0) begin
            #1 clr = 1'b1;
            #1 clr = 1'b0;
         end
         drive($urandom_range(7) == 0, W'($urandom), $urandom_range(3) != 0, md,
               1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
